// File: rtl/xif_issue_drv_pkg.sv
// Shared types and default widths for the XIF issue driver and its ID scoreboard.
package xif_issue_drv_pkg;

  localparam int unsigned DEF_ID_WIDTH        = 4;
  localparam int unsigned DEF_RFR_WIDTH       = 32;
  localparam int unsigned DEF_RFW_WIDTH       = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // One result transaction at the default widths.
  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]  id;
    logic [4:0]               rd;
    logic                     we;
    logic [DEF_RFW_WIDTH-1:0] data;
  } result_rec_t;

endpackage

// File: rtl/xif_id_scoreboard.sv
// Outstanding-ID bit vector with occupancy count, free check for the next ID and
// detection of results that name an ID that is not outstanding.
module xif_id_scoreboard #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_i,
  input  logic [ID_WIDTH-1:0] set_id_i,
  input  logic                clr_req_i,
  input  logic [ID_WIDTH-1:0] clr_id_i,
  input  logic [ID_WIDTH-1:0] query_id_i,
  output logic                free_o,
  output logic                clr_hit_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int unsigned DEPTH = 2 ** ID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DEPTH-1:0]     bits_q;
  logic [CNT_WIDTH-1:0] count_q;

  assign clr_hit_o = clr_req_i && bits_q[clr_id_i];
  assign err_o     = clr_req_i && !bits_q[clr_id_i];
  assign free_o    = (count_q < MAX_CNT) && !bits_q[query_id_i];
  assign busy_o    = (count_q != '0);

  // NOTE: the valid bits must be reset, unlike a data RAM: a stale bit would
  // block an ID forever and make a stray result look legitimate.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bits_q  <= '0;
      count_q <= '0;
    end else begin
      if (set_i)     bits_q[set_id_i] <= 1'b1;
      if (clr_hit_o) bits_q[clr_id_i] <= 1'b0;
      // Simultaneous set and clear leave the count unchanged.
      unique case ({set_i, clr_hit_o})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xif_issue_driver.sv
// Core-side XIF master: issue handshake, one commit per issued ID, result drain
// into register-file writebacks. Define XIF_ISSUE_DRV_PERF_EN for perf counters.
module xif_issue_driver
  import xif_issue_drv_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH      = DEF_ID_WIDTH,
  parameter int unsigned X_RFR_WIDTH     = DEF_RFR_WIDTH,
  parameter int unsigned X_RFW_WIDTH     = DEF_RFW_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [31:0]            instr_i,
  input  logic [X_RFR_WIDTH-1:0] rs1_i,
  input  logic [X_RFR_WIDTH-1:0] rs2_i,
  input  logic                   kill_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs2_o,
  input  logic                   issue_accept_i,
  output logic                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  output logic                   commit_kill_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [4:0]             result_rd_i,
  input  logic                   result_we_i,
  input  logic [X_RFW_WIDTH-1:0] result_data_i,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFW_WIDTH-1:0] wb_data_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef XIF_ISSUE_DRV_PERF_EN
  ,
  output logic [31:0]            perf_issued_o,
  output logic [31:0]            perf_rejected_o,
  output logic [31:0]            perf_killed_o,
  output logic [31:0]            perf_results_o
`endif
);

  localparam logic [X_ID_WIDTH-1:0] ID_ONE = X_ID_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [X_ID_WIDTH-1:0]  next_id_q;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q, rs2_q;
  logic                   kill_q, accept_q;
  logic                   instr_hs, issue_hs, sb_set;
  logic                   sb_free, sb_hit, sb_err, sb_busy;
  logic                   wb_valid_q, err_q;
  logic [4:0]             wb_rd_q;
  logic [X_RFW_WIDTH-1:0] wb_data_q;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    instr_ready_o  = 1'b0;
    issue_valid_o  = 1'b0;
    commit_valid_o = 1'b0;
    instr_hs       = 1'b0;
    issue_hs       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Refuse while full or while the next ID still awaits its result.
        instr_ready_o = sb_free && !rst_i;
        instr_hs      = instr_valid_i && instr_ready_o;
        if (instr_hs) state_d = ISSUE;
      end
      ISSUE: begin
        issue_valid_o = 1'b1;
        issue_hs      = issue_ready_i;
        if (issue_hs) state_d = COMMIT;
      end
      COMMIT: begin
        commit_valid_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sb_set         = commit_valid_o && accept_q && !kill_q;
  assign commit_kill_o  = commit_valid_o && (kill_q || !accept_q);
  assign commit_id_o    = commit_valid_o ? next_id_q : '0;
  assign issue_instr_o  = instr_q;
  assign issue_id_o     = next_id_q;
  assign issue_rs1_o    = rs1_q;
  assign issue_rs2_o    = rs2_q;
  assign result_ready_o = 1'b1;
  assign busy_o         = (state_q != IDLE) || sb_busy;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign err_o          = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      next_id_q <= '0;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      kill_q    <= 1'b0;
      accept_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_hs) begin
        instr_q <= instr_i;
        rs1_q   <= rs1_i;
        rs2_q   <= rs2_i;
        kill_q  <= kill_i;
      end
      if (issue_hs)       accept_q  <= issue_accept_i;
      if (commit_valid_o) next_id_q <= next_id_q + ID_ONE;
    end
  end

  // Results are never back-pressured; a hit clears the ID and may write back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= sb_hit && result_we_i;
      if (sb_hit && result_we_i) begin
        wb_rd_q   <= result_rd_i;
        wb_data_q <= result_data_i;
      end
      if (sb_err) err_q <= 1'b1;
    end
  end

  xif_id_scoreboard #(
    .ID_WIDTH        (X_ID_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (sb_set),
    .set_id_i   (next_id_q),
    .clr_req_i  (result_valid_i),
    .clr_id_i   (result_id_i),
    .query_id_i (next_id_q),
    .free_o     (sb_free),
    .clr_hit_o  (sb_hit),
    .err_o      (sb_err),
    .busy_o     (sb_busy)
  );

`ifdef XIF_ISSUE_DRV_PERF_EN
  logic [31:0] perf_issued_q, perf_rejected_q, perf_killed_q, perf_results_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_issued_q   <= '0;
      perf_rejected_q <= '0;
      perf_killed_q   <= '0;
      perf_results_q  <= '0;
    end else begin
      if (issue_hs && perf_issued_q != '1)                    perf_issued_q   <= perf_issued_q + 32'd1;
      if (commit_valid_o && !accept_q && perf_rejected_q != '1) perf_rejected_q <= perf_rejected_q + 32'd1;
      if (commit_valid_o && kill_q && perf_killed_q != '1)    perf_killed_q   <= perf_killed_q + 32'd1;
      if (sb_hit && perf_results_q != '1)                     perf_results_q  <= perf_results_q + 32'd1;
    end
  end

  assign perf_issued_o   = perf_issued_q;
  assign perf_rejected_o = perf_rejected_q;
  assign perf_killed_o   = perf_killed_q;
  assign perf_results_o  = perf_results_q;
`endif

endmodule

// File: tb/tb_xif_issue_driver.sv
// Self-checking bench for xif_issue_driver: vector table plus hand-written
// sequences; expected commits and writebacks are queued and popped by monitors.
module tb_xif_issue_driver;
  import xif_issue_drv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i, instr_ready_o;
  logic [31:0] instr_i, rs1_i, rs2_i;
  logic        kill_i;
  logic        issue_valid_o, issue_ready_i;
  logic [31:0] issue_instr_o, issue_rs1_o, issue_rs2_o;
  logic [3:0]  issue_id_o;
  logic        issue_accept_i;
  logic        commit_valid_o, commit_kill_o;
  logic [3:0]  commit_id_o;
  logic        result_valid_i, result_ready_o;
  logic [3:0]  result_id_i;
  logic [4:0]  result_rd_i;
  logic        result_we_i;
  logic [31:0] result_data_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        busy_o, err_o;

  always #5 clk_i = ~clk_i;

  xif_issue_driver dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_valid_i  (instr_valid_i),
    .instr_ready_o  (instr_ready_o),
    .instr_i        (instr_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .kill_i         (kill_i),
    .issue_valid_o  (issue_valid_o),
    .issue_ready_i  (issue_ready_i),
    .issue_instr_o  (issue_instr_o),
    .issue_id_o     (issue_id_o),
    .issue_rs1_o    (issue_rs1_o),
    .issue_rs2_o    (issue_rs2_o),
    .issue_accept_i (issue_accept_i),
    .commit_valid_o (commit_valid_o),
    .commit_id_o    (commit_id_o),
    .commit_kill_o  (commit_kill_o),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .result_id_i    (result_id_i),
    .result_rd_i    (result_rd_i),
    .result_we_i    (result_we_i),
    .result_data_i  (result_data_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  typedef struct packed {
    logic [3:0] id;
    logic       kill;
  } commit_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        accept;
    int          delay;
    logic        res_en;
    logic        res_we;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        exp_kill;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  commit_t     cm_q[$];
  result_rec_t wb_q[$];
  logic [15:0] model_out;
  logic [3:0]  model_next;
  vec_t        vecs[6];
  logic [3:0]  ids[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic exp_ready();
    return ($countones(model_out) < 4) && !model_out[model_next];
  endfunction

  // Monitors sample on the falling edge, away from the active clock edge.
  always @(negedge clk_i) begin
    if (commit_valid_o) begin
      if (cm_q.size() == 0) check("commit_unexpected", commit_valid_o, 1'b0);
      else begin
        commit_t e;
        e = cm_q.pop_front();
        check("commit_id", commit_id_o, e.id);
        check("commit_kill", commit_kill_o, e.kill);
      end
    end
    if (wb_valid_o) begin
      if (wb_q.size() == 0) check("wb_unexpected", wb_valid_o, 1'b0);
      else begin
        result_rec_t r;
        r = wb_q.pop_front();
        check("wb_rd", wb_rd_o, r.rd);
        check("wb_data", wb_data_o, r.data);
      end
    end
  end

  // Drives a result for the current cycle; caller deasserts on the next falling edge.
  task automatic drive_result(input logic [3:0] id, input logic [4:0] rd, input logic we,
                              input logic [31:0] data);
    result_rec_t r;
    result_valid_i = 1'b1;
    result_id_i    = id;
    result_rd_i    = rd;
    result_we_i    = we;
    result_data_i  = data;
    if (model_out[id]) begin
      model_out[id] = 1'b0;
      if (we) begin
        r = '{id: id, rd: rd, we: we, data: data};
        wb_q.push_back(r);
      end
    end
  endtask

  task automatic send_result(input logic [3:0] id, input logic [4:0] rd, input logic we,
                             input logic [31:0] data);
    drive_result(id, rd, we, data);
    @(negedge clk_i);
    result_valid_i = 1'b0;
  endtask

  task automatic do_issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic kill, input logic accept, input logic exp_kill,
                          input int delay, input logic coll_en, input logic [3:0] coll_id,
                          output logic [3:0] id);
    int k;
    commit_t c;
    k  = 0;
    id = model_next;
    while (!instr_ready_o && k < 64) begin
      @(negedge clk_i);
      k++;
    end
    if (!instr_ready_o) begin
      check("instr_ready_timeout", instr_ready_o, 1'b1);
      return;
    end
    instr_valid_i = 1'b1;
    instr_i = instr;
    rs1_i   = rs1;
    rs2_i   = rs2;
    kill_i  = kill;
    @(negedge clk_i);
    instr_valid_i  = 1'b0;
    instr_i        = ~instr;
    rs1_i          = ~rs1;
    rs2_i          = ~rs2;
    kill_i         = ~kill;
    issue_accept_i = ~accept;
    for (int cyc = 0; cyc <= delay; cyc++) begin
      check("issue_valid", issue_valid_o, 1'b1);
      check("issue_id", issue_id_o, id);
      check("issue_instr", issue_instr_o, instr);
      check("issue_rs1", issue_rs1_o, rs1);
      check("issue_rs2", issue_rs2_o, rs2);
      if (cyc < delay) @(negedge clk_i);
    end
    issue_ready_i  = 1'b1;
    issue_accept_i = accept;
    c = '{id: id, kill: exp_kill};
    cm_q.push_back(c);
    if (accept && !kill) model_out[id] = 1'b1;
    model_next = model_next + 4'd1;
    @(negedge clk_i);
    issue_ready_i  = 1'b0;
    issue_accept_i = 1'b0;
    if (coll_en) drive_result(coll_id, 5'd1, 1'b1, 32'h0000_00AA);
    @(negedge clk_i);
    result_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] id;
    logic [3:0] a_id, b_id, c_id, d_id, e_id, f_id;

    rst_i = 1'b1;
    instr_valid_i = 1'b0; instr_i = '0; rs1_i = '0; rs2_i = '0; kill_i = 1'b0;
    issue_ready_i = 1'b0; issue_accept_i = 1'b0;
    result_valid_i = 1'b0; result_id_i = '0; result_rd_i = '0; result_we_i = 1'b0; result_data_i = '0;
    model_out = '0;
    model_next = '0;

    vecs[0] = '{instr: 32'h0000_000B, rs1: 32'd5, rs2: 32'd7, kill: 1'b0, accept: 1'b1, delay: 0,
                res_en: 1'b1, res_we: 1'b1, res_rd: 5'd3, res_data: 32'd12, exp_kill: 1'b0};
    vecs[1] = '{instr: 32'h0000_102B, rs1: 32'd1, rs2: 32'd2, kill: 1'b0, accept: 1'b0, delay: 0,
                res_en: 1'b0, res_we: 1'b0, res_rd: 5'd0, res_data: 32'd0, exp_kill: 1'b1};
    vecs[2] = '{instr: 32'h0000_205B, rs1: 32'd9, rs2: 32'd4, kill: 1'b1, accept: 1'b1, delay: 0,
                res_en: 1'b0, res_we: 1'b0, res_rd: 5'd0, res_data: 32'd0, exp_kill: 1'b1};
    vecs[3] = '{instr: 32'h0000_307B, rs1: 32'hAAAA_5555, rs2: 32'h5555_AAAA, kill: 1'b0, accept: 1'b1,
                delay: 1, res_en: 1'b1, res_we: 1'b0, res_rd: 5'd8, res_data: 32'h1111_2222, exp_kill: 1'b0};
    vecs[4] = '{instr: 32'h0000_400B, rs1: 32'd0, rs2: 32'hFFFF_FFFF, kill: 1'b0, accept: 1'b1, delay: 0,
                res_en: 1'b1, res_we: 1'b1, res_rd: 5'd0, res_data: 32'hDEAD_BEEF, exp_kill: 1'b0};
    vecs[5] = '{instr: 32'hFFFF_FF8B, rs1: 32'h8000_0000, rs2: 32'h0000_0001, kill: 1'b0, accept: 1'b1,
                delay: 5, res_en: 1'b1, res_we: 1'b1, res_rd: 5'd31, res_data: 32'hFFFF_FFFF, exp_kill: 1'b0};

    repeat (2) @(negedge clk_i);
    check("rst_instr_ready", instr_ready_o, 1'b0);
    check("rst_issue_valid", issue_valid_o, 1'b0);
    check("rst_issue_id", issue_id_o, 4'd0);
    check("rst_issue_instr", issue_instr_o, 32'd0);
    check("rst_commit_valid", commit_valid_o, 1'b0);
    check("rst_commit_kill", commit_kill_o, 1'b0);
    check("rst_result_ready", result_ready_o, 1'b1);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", instr_ready_o, 1'b1);
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      do_issue(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].kill, vecs[i].accept,
               vecs[i].exp_kill, vecs[i].delay, 1'b0, 4'd0, id);
      ids[i] = id;
      if (vecs[i].res_en) send_result(id, vecs[i].res_rd, vecs[i].res_we, vecs[i].res_data);
      check("row_busy", busy_o, |model_out);
      check("row_ready", instr_ready_o, exp_ready());
      check("row_err", err_o, 1'b0);
    end

    // Result for the killed ID: sticky error, no writeback.
    send_result(ids[2], 5'd9, 1'b1, 32'h0000_1234);
    check("err_stray_result", err_o, 1'b1);
    @(negedge clk_i);
    check("err_sticky", err_o, 1'b1);

    // Limit: result collides with a commit, then fill to four outstanding.
    do_issue(32'h0000_500B, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, a_id);
    do_issue(32'h0000_600B, 32'd2, 32'd2, 1'b0, 1'b1, 1'b0, 0, 1'b1, a_id, b_id);
    do_issue(32'h0000_700B, 32'd3, 32'd3, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, c_id);
    do_issue(32'h0000_800B, 32'd4, 32'd4, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, d_id);
    check("ready_before_full", instr_ready_o, 1'b1);
    do_issue(32'h0000_900B, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, e_id);
    check("full_ready", instr_ready_o, 1'b0);
    check("full_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("full_ready_hold", instr_ready_o, 1'b0);
    send_result(b_id, 5'd2, 1'b1, 32'h0000_0B0B);
    check("ready_after_drain", instr_ready_o, 1'b1);
    send_result(c_id, 5'd3, 1'b1, 32'h0000_0C0C);
    send_result(d_id, 5'd4, 1'b1, 32'h0000_0D0D);
    send_result(e_id, 5'd5, 1'b1, 32'h0000_0E0E);
    check("drained_busy", busy_o, 1'b0);

    // Wrap: one outstanding ID, rejects walk next_id all the way round to it.
    do_issue(32'h0000_A00B, 32'd6, 32'd6, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, f_id);
    for (int i = 0; i < 15; i++)
      do_issue(32'h0001_000B + i, i, i, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4'd0, id);
    check("occupied_ready", instr_ready_o, 1'b0);
    check("occupied_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("occupied_ready_hold", instr_ready_o, 1'b0);
    send_result(f_id, 5'd7, 1'b1, 32'h0000_F0F0);
    check("occupied_released", instr_ready_o, 1'b1);
    do_issue(32'h0000_B00B, 32'd7, 32'd8, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, id);
    check("reused_id", id, f_id);
    send_result(id, 5'd10, 1'b1, 32'h0000_0015);

    // Reset while the issue request is pending.
    instr_valid_i = 1'b1;
    instr_i = 32'h0000_0077;
    rs1_i = 32'd11;
    rs2_i = 32'd22;
    kill_i = 1'b0;
    check("pre_reset_ready", instr_ready_o, 1'b1);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    check("pre_reset_issue_valid", issue_valid_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_issue_valid", issue_valid_o, 1'b0);
    check("midrst_issue_id", issue_id_o, 4'd0);
    check("midrst_issue_instr", issue_instr_o, 32'd0);
    check("midrst_commit_valid", commit_valid_o, 1'b0);
    check("midrst_instr_ready", instr_ready_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_err", err_o, 1'b0);
    check("midrst_result_ready", result_ready_o, 1'b1);
    model_out  = '0;
    model_next = '0;
    rst_i = 1'b0;
    @(negedge clk_i);
    do_issue(32'h0000_C00B, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'd0, id);
    send_result(id, 5'd12, 1'b1, 32'h0000_0007);
    @(negedge clk_i);
    check("final_busy", busy_o, 1'b0);
    check("commits_drained", cm_q.size(), 0);
    check("writebacks_drained", wb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
